fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Program counter and run/halt sequencer for the 9-bit core; one instruction per cycle.
// All outputs registered; PC update follows decoder controls sampled at the cycle's closing edge.
module fetch_unit #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             BranchEn,
  input  logic             BranchOnFlag,
  input  logic             Done,
  input  logic             Zero,
  input  logic [PC_W-1:0]  BranchTarget,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Ack,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] BranchCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] br_q;
  logic             running_q;
  logic             ack_q;

  logic [PC_W-1:0]  pc_inc_d;
  logic [CNT_W-1:0] cyc_inc_d;
  logic [CNT_W-1:0] br_inc_d;
  logic             taken_d;

  // PC wraps naturally at 2^PC_W; counters stick at all-ones.
  assign pc_inc_d  = pc_q + PC_W'(1);
  assign cyc_inc_d = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);
  assign br_inc_d  = (&br_q)  ? br_q  : br_q  + CNT_W'(1);
  assign taken_d   = BranchEn && (Zero == BranchOnFlag);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cyc_q     <= '0;
      br_q      <= '0;
      running_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_HALT: begin
          if (Start) begin
            state_q   <= S_RUN;
            pc_q      <= StartAddr;
            cyc_q     <= '0;
            br_q      <= '0;
            running_q <= 1'b1;
            ack_q     <= 1'b0;
          end
        end
        S_RUN: begin
          cyc_q <= cyc_inc_d;
          // Halt outranks a branch decoded in the same instruction.
          if (Done) begin
            state_q   <= S_HALT;
            running_q <= 1'b0;
            ack_q     <= 1'b1;
          end else if (taken_d) begin
            pc_q <= BranchTarget;
            br_q <= br_inc_d;
          end else begin
            pc_q <= pc_inc_d;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
          ack_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ProgCtr     = pc_q;
  assign Running     = running_q;
  assign Ack         = ack_q;
  assign CycleCount  = cyc_q;
  assign BranchCount = br_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, saturation sequence, randomized run against a reference model.
module tb_fetch_unit;
  localparam int PC_W = 10;

  logic            Clk = 1'b0;
  logic            Reset, Start, BranchEn, BranchOnFlag, Done, Zero;
  logic [PC_W-1:0] StartAddr, BranchTarget;

  logic [PC_W-1:0] pc_a, pc_b;
  logic            run_a, ack_a, run_b, ack_b;
  logic [15:0]     cyc_a, br_a;
  logic [3:0]      cyc_b, br_b;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  fetch_unit #(.PC_W(PC_W), .CNT_W(16)) dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .BranchEn(BranchEn), .BranchOnFlag(BranchOnFlag), .Done(Done), .Zero(Zero),
    .BranchTarget(BranchTarget), .ProgCtr(pc_a), .Running(run_a), .Ack(ack_a),
    .CycleCount(cyc_a), .BranchCount(br_a)
  );

  fetch_unit #(.PC_W(PC_W), .CNT_W(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .BranchEn(BranchEn), .BranchOnFlag(BranchOnFlag), .Done(Done), .Zero(Zero),
    .BranchTarget(BranchTarget), .ProgCtr(pc_b), .Running(run_b), .Ack(ack_b),
    .CycleCount(cyc_b), .BranchCount(br_b)
  );

  // Reference model: 0 = idle, 1 = running, 2 = halted; counts kept unbounded.
  int m_mode = 0;
  int m_pc = 0;
  int m_cyc = 0;
  int m_br = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (Reset) begin
      m_mode = 0; m_pc = 0; m_cyc = 0; m_br = 0;
    end else if (m_mode == 1) begin
      m_cyc++;
      if (Done) m_mode = 2;
      else if (BranchEn && (Zero == BranchOnFlag)) begin
        m_pc = int'(BranchTarget); m_br++;
      end else m_pc = (m_pc + 1) % (1 << PC_W);
    end else if (Start) begin
      m_mode = 1; m_pc = int'(StartAddr); m_cyc = 0; m_br = 0;
    end
  endtask

  task automatic drive(input logic r, input logic s, input int sa, input logic be,
                       input logic bf, input logic dn, input logic z, input int bt);
    Reset = r; Start = s; StartAddr = PC_W'(sa); BranchEn = be;
    BranchOnFlag = bf; Done = dn; Zero = z; BranchTarget = PC_W'(bt);
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic r, s, be, bf, dn, z;
    int   sa, bt;
    int   pc, cyc, br;
    logic run, ack;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input int sa, input logic be, input logic bf,
                     input logic dn, input logic z, input int bt,
                     input int pc, input logic run, input logic ack, input int cyc, input int br);
    vec_t v;
    v.r = r; v.s = s; v.sa = sa; v.be = be; v.bf = bf; v.dn = dn; v.z = z; v.bt = bt;
    v.pc = pc; v.run = run; v.ack = ack; v.cyc = cyc; v.br = br;
    vecs.push_back(v);
  endtask

  initial begin
    //  r  s  sa     be bf dn z  bt       pc     run ack cyc br
    add(1, 0, 0,     0, 0, 0, 0, 0,       0,     0, 0, 0, 0);
    add(0, 1, 5,     0, 0, 0, 0, 0,       5,     1, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0,       6,     1, 0, 1, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0,       7,     1, 0, 2, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0,       8,     1, 0, 3, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0,       9,     1, 0, 4, 0);
    add(0, 1, 'h100, 0, 0, 0, 0, 0,       'h0A,  1, 0, 5, 0);
    add(1, 0, 0,     0, 0, 0, 0, 0,       0,     0, 0, 0, 0);
    add(0, 1, 'h10,  0, 0, 0, 0, 0,       'h10,  1, 0, 0, 0);
    add(0, 0, 0,     1, 1, 0, 1, 'h80,    'h80,  1, 0, 1, 1);
    add(0, 0, 0,     1, 0, 0, 0, 'h10,    'h10,  1, 0, 2, 2);
    add(0, 0, 0,     1, 1, 0, 0, 'h80,    'h11,  1, 0, 3, 2);
    add(0, 0, 0,     1, 0, 0, 1, 'h55,    'h12,  1, 0, 4, 2);
    add(0, 0, 0,     1, 1, 0, 1, 'h20,    'h20,  1, 0, 5, 3);
    add(0, 0, 0,     1, 1, 1, 1, 'h99,    'h20,  0, 1, 6, 3);
    add(0, 0, 0,     1, 1, 1, 1, 'h99,    'h20,  0, 1, 6, 3);
    add(0, 1, 0,     0, 0, 0, 0, 0,       0,     1, 0, 0, 0);
    add(0, 0, 0,     1, 1, 0, 1, 'h44,    'h44,  1, 0, 1, 1);
    add(1, 0, 0,     1, 1, 1, 1, 'h77,    0,     0, 0, 0, 0);
    add(0, 0, 0,     1, 1, 1, 1, 'h77,    0,     0, 0, 0, 0);
    add(1, 1, 'h123, 0, 0, 0, 0, 0,       0,     0, 0, 0, 0);
    add(0, 1, 'h3FE, 0, 0, 0, 0, 0,       'h3FE, 1, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0,       'h3FF, 1, 0, 1, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0,       0,     1, 0, 2, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0,       1,     1, 0, 3, 0);
    add(0, 0, 0,     0, 0, 1, 0, 0,       1,     0, 1, 4, 0);

    @(negedge Clk);
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].sa, vecs[i].be, vecs[i].bf, vecs[i].dn, vecs[i].z, vecs[i].bt);
      chk($sformatf("vec%0d pc", i),   32'(pc_a),  32'(vecs[i].pc));
      chk($sformatf("vec%0d run", i),  32'(run_a), 32'(vecs[i].run));
      chk($sformatf("vec%0d ack", i),  32'(ack_a), 32'(vecs[i].ack));
      chk($sformatf("vec%0d cyc", i),  32'(cyc_a), 32'(vecs[i].cyc));
      chk($sformatf("vec%0d br", i),   32'(br_a),  32'(vecs[i].br));
      chk($sformatf("vec%0d cyc4", i), 32'(cyc_b), 32'(sat(vecs[i].cyc, 15)));
    end

    // Saturation: 20 sequential then 20 taken-branch instructions on the narrow counters.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("sat seq%0d cyc4", i), 32'(cyc_b), 32'(sat(i, 15)));
      chk($sformatf("sat seq%0d cyc16", i), 32'(cyc_a), 32'(i));
    end
    drive(0, 1, 0, 0, 0, 1, 0, 0);
    drive(0, 1, 'h200, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0, i * 7);
      chk($sformatf("sat br%0d br4", i), 32'(br_b), 32'(sat(i, 15)));
      chk($sformatf("sat br%0d pc", i), 32'(pc_b), 32'(i * 7));
    end

    // Randomized run against the model.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      int sa;
      sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1020, 1023)) : int'($urandom_range(0, 1023));
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0, sa,
            $urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 11) == 0,
            1'($urandom), int'($urandom_range(0, 1023)));
      chk("rnd pc",    32'(pc_a),  32'(m_pc));
      chk("rnd run",   32'(run_a), 32'(m_mode == 1));
      chk("rnd ack",   32'(ack_a), 32'(m_mode == 2));
      chk("rnd cyc",   32'(cyc_a), 32'(sat(m_cyc, 65535)));
      chk("rnd br",    32'(br_a),  32'(sat(m_br, 65535)));
      chk("rnd cyc4",  32'(cyc_b), 32'(sat(m_cyc, 15)));
      chk("rnd br4",   32'(br_b),  32'(sat(m_br, 15)));
      chk("rnd excl",  32'(run_b & ack_b), 32'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
